// File: rtl/brush_controller.sv
// Brush state generator for the paint frame buffer: synchronises and debounces
// the raw buttons/switch, steps the brush box once per frame with hold-to-repeat,
// clamps it to the visible screen and cycles an 8-entry paint palette.
//
// state      | meaning
// ST_IDLE    | no direction held; first tick with a direction moves at once
// ST_FIRST   | first move done, waiting REPEAT_FRAMES frames for the first repeat
// ST_REPEAT  | repeating a move every REPEAT_FRAMES frames while held
module brush_controller #(
   parameter int H_RES           = 640,
   parameter int V_RES           = 480,
   parameter int BOX_WIDTH       = 10,
   parameter int BOX_HEIGHT      = 10,
   parameter int STEP            = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_FRAMES   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_color,
   input  logic       sw_paint,
   output logic [9:0] box_x,
   output logic [9:0] box_y,
   output logic       paint_enable,
   output logic [3:0] red_out,
   output logic [3:0] green_out,
   output logic [3:0] blue_out
);

   localparam int NIN = 6;
   localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int FW  = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FW-1:0] RF_LAST = FW'(REPEAT_FRAMES - 1);
   localparam logic [10:0] STEP_W = 11'(STEP);
   localparam logic [10:0] X_MAX  = 11'(H_RES - BOX_WIDTH);
   localparam logic [10:0] Y_MAX  = 11'(V_RES - BOX_HEIGHT);
   localparam logic [9:0]  X_RST  = 10'((H_RES - BOX_WIDTH) / 2);
   localparam logic [9:0]  Y_RST  = 10'((V_RES - BOX_HEIGHT) / 2);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FIRST  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   // bit order: 0 up, 1 down, 2 left, 3 right, 4 color, 5 paint
   logic [NIN-1:0] raw_in, sync_a, sync_b, deb;
   logic [CW-1:0]  db_cnt [NIN];
   logic           deb_color_d;
   logic [2:0]     pal_idx;
   logic [1:0]     state;
   logic [FW-1:0]  frame_cnt;
   logic           go_up, go_down, go_left, go_right, held, do_move;
   logic [9:0]     x_next, y_next;

   assign raw_in = {sw_paint, btn_color, btn_right, btn_left, btn_down, btn_up};

   // Pull down by STEP, clamping at zero; 11-bit math so nothing wraps.
   function automatic logic [9:0] step_minus(input logic [9:0] p);
      logic [10:0] e;
      e = {1'b0, p};
      return (e < STEP_W) ? 10'd0 : 10'(e - STEP_W);
   endfunction

   // Push up by STEP, clamping so the box's far edge stays on screen.
   function automatic logic [9:0] step_plus(input logic [9:0] p, input logic [10:0] lim);
      logic [10:0] s;
      s = {1'b0, p} + STEP_W;
      return (s > lim) ? 10'(lim) : 10'(s);
   endfunction

   // Two-flop synchroniser for every raw input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= raw_in;
         sync_b <= sync_a;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb <= '0;
         for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NIN; i++) begin
            if (sync_b[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= sync_b[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Paint enable and palette index advance on the debounced colour press edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         paint_enable <= 1'b0;
         deb_color_d  <= 1'b0;
         pal_idx      <= 3'd0;
      end else begin
         paint_enable <= deb[5];
         deb_color_d  <= deb[4];
         if (deb[4] && !deb_color_d) pal_idx <= pal_idx + 3'd1;
      end
   end

   // Registered palette lookup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {red_out, green_out, blue_out} <= 12'hFFF;
      end else begin
         case (pal_idx)
            3'd0:    {red_out, green_out, blue_out} <= 12'hFFF;
            3'd1:    {red_out, green_out, blue_out} <= 12'hF00;
            3'd2:    {red_out, green_out, blue_out} <= 12'h0F0;
            3'd3:    {red_out, green_out, blue_out} <= 12'h00F;
            3'd4:    {red_out, green_out, blue_out} <= 12'hFF0;
            3'd5:    {red_out, green_out, blue_out} <= 12'h0FF;
            3'd6:    {red_out, green_out, blue_out} <= 12'hF0F;
            default: {red_out, green_out, blue_out} <= 12'h000;
         endcase
      end
   end

   // Direction vector, move strobe and clamped next position.
   always_comb begin
      go_up    = deb[0] & ~deb[1];
      go_down  = deb[1] & ~deb[0];
      go_left  = deb[2] & ~deb[3];
      go_right = deb[3] & ~deb[2];
      held     = go_up | go_down | go_left | go_right;
      do_move  = 1'b0;
      if (held && frame_tick) begin
         if (state == ST_IDLE) do_move = 1'b1;
         else if (frame_cnt == RF_LAST) do_move = 1'b1;
      end
      x_next = box_x;
      if (go_left)       x_next = step_minus(box_x);
      else if (go_right) x_next = step_plus(box_x, X_MAX);
      y_next = box_y;
      if (go_up)         y_next = step_minus(box_y);
      else if (go_down)  y_next = step_plus(box_y, Y_MAX);
   end

   // Movement FSM with frame-based repeat timer and box position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         frame_cnt <= '0;
         box_x     <= X_RST;
         box_y     <= Y_RST;
      end else begin
         if (do_move) begin
            box_x <= x_next;
            box_y <= y_next;
         end
         case (state)
            ST_IDLE: begin
               if (held && frame_tick) begin
                  state     <= ST_FIRST;
                  frame_cnt <= '0;
               end
            end
            default: begin
               if (!held) begin
                  state     <= ST_IDLE;
                  frame_cnt <= '0;
               end else if (frame_tick) begin
                  if (frame_cnt == RF_LAST) begin
                     frame_cnt <= '0;
                     state     <= ST_REPEAT;
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
